// File: rtl/i2c_slave_regif.sv
// I2C responder exposing a 16-bit register pointer. It emits one-clk write strobes and read
// requests, and serialises the returned read data on SDA.
module i2c_slave_regif #(
    parameter logic [6:0] SLAVE_ADDR  = 7'b1010000,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i2c_scl,
    inout  wire         i2c_sda,
    output logic        o_wr_en,
    output logic [15:0] o_wr_addr,
    output logic [7:0]  o_wr_data,
    output logic        o_rd_req,
    output logic [15:0] o_rd_addr,
    input  logic [7:0]  i_rd_data,
    output logic        o_busy
);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        DEV_ADDR  = 4'd1,
        DEV_ACK   = 4'd2,
        PTR_H     = 4'd3,
        PTR_H_ACK = 4'd4,
        PTR_L     = 4'd5,
        PTR_L_ACK = 4'd6,
        WR_DATA   = 4'd7,
        WR_ACK    = 4'd8,
        RD_DATA   = 4'd9,
        RD_ACK    = 4'd10,
        WAIT_STOP = 4'd11
    } state_t;

    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic                   r_scl_d;
    logic                   r_sda_d;
    state_t                 r_state;
    logic [3:0]             r_cnt;
    logic [7:0]             r_shift;
    logic [15:0]            r_ptr;
    logic                   r_sda_oe;
    logic                   r_rw;
    logic                   r_mack;
    logic                   r_rd_cap;

    logic w_scl;
    logic w_sda;
    logic w_scl_rise;
    logic w_scl_fall;
    logic w_start;
    logic w_stop;
    logic [7:0] w_byte;

    assign w_scl      = r_scl_sync[SYNC_STAGES-1];
    assign w_sda      = r_sda_sync[SYNC_STAGES-1];
    assign w_scl_rise = w_scl & ~r_scl_d;
    assign w_scl_fall = ~w_scl & r_scl_d;
    assign w_start    = w_scl & r_scl_d & r_sda_d & ~w_sda;
    assign w_stop     = w_scl & r_scl_d & ~r_sda_d & w_sda;
    assign w_byte     = {r_shift[6:0], w_sda};

    // Open drain: only ever pull low or release.
    assign i2c_sda = r_sda_oe ? 1'b0 : 1'bz;

    // Input synchronisers plus one delayed copy for edge / START / STOP detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_scl_sync <= {SYNC_STAGES{1'b1}};
            r_sda_sync <= {SYNC_STAGES{1'b1}};
            r_scl_d    <= 1'b1;
            r_sda_d    <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], i2c_scl};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], i2c_sda};
            r_scl_d    <= w_scl;
            r_sda_d    <= w_sda;
        end
    end

    // Protocol FSM; STOP outranks START, and both outrank any in-flight byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= 4'd0;
            r_shift   <= 8'd0;
            r_ptr     <= 16'd0;
            r_sda_oe  <= 1'b0;
            r_rw      <= 1'b0;
            r_mack    <= 1'b0;
            r_rd_cap  <= 1'b0;
            o_wr_en   <= 1'b0;
            o_wr_addr <= 16'd0;
            o_wr_data <= 8'd0;
            o_rd_req  <= 1'b0;
            o_rd_addr <= 16'd0;
            o_busy    <= 1'b0;
        end else begin
            o_wr_en  <= 1'b0;
            o_rd_req <= 1'b0;
            r_rd_cap <= 1'b0;
            if (w_stop) begin
                r_state  <= IDLE;
                r_sda_oe <= 1'b0;
                o_busy   <= 1'b0;
            end else if (w_start) begin
                r_state  <= DEV_ADDR;
                r_cnt    <= 4'd0;
                r_sda_oe <= 1'b0;
            end else begin
                // Read data arrives the clk after o_rd_req; put its MSB straight onto SDA.
                if (r_rd_cap) begin
                    r_shift  <= i_rd_data;
                    r_sda_oe <= ~i_rd_data[7];
                end
                case (r_state)
                    IDLE: begin
                    end
                    DEV_ADDR: begin
                        if (w_scl_rise) begin
                            r_shift <= w_byte;
                            r_cnt   <= r_cnt + 4'd1;
                        end else if (w_scl_fall && r_cnt == 4'd8) begin
                            if (r_shift[7:1] == SLAVE_ADDR) begin
                                r_sda_oe <= 1'b1;
                                r_rw     <= r_shift[0];
                                o_busy   <= 1'b1;
                                r_state  <= DEV_ACK;
                            end else begin
                                r_sda_oe <= 1'b0;
                                o_busy   <= 1'b0;
                                r_state  <= WAIT_STOP;
                            end
                        end
                    end
                    DEV_ACK: begin
                        if (w_scl_fall) begin
                            r_sda_oe <= 1'b0;
                            r_cnt    <= 4'd0;
                            if (r_rw) begin
                                r_state   <= RD_DATA;
                                o_rd_req  <= 1'b1;
                                o_rd_addr <= r_ptr;
                                r_rd_cap  <= 1'b1;
                            end else begin
                                r_state <= PTR_H;
                            end
                        end
                    end
                    PTR_H, PTR_L: begin
                        if (w_scl_rise) begin
                            r_shift <= w_byte;
                            r_cnt   <= r_cnt + 4'd1;
                        end else if (w_scl_fall && r_cnt == 4'd8) begin
                            if (r_state == PTR_H) begin
                                r_ptr[15:8] <= r_shift;
                                r_state     <= PTR_H_ACK;
                            end else begin
                                r_ptr[7:0] <= r_shift;
                                r_state    <= PTR_L_ACK;
                            end
                            r_sda_oe <= 1'b1;
                        end
                    end
                    PTR_H_ACK, PTR_L_ACK, WR_ACK: begin
                        if (w_scl_fall) begin
                            r_sda_oe <= 1'b0;
                            r_cnt    <= 4'd0;
                            r_state  <= (r_state == PTR_H_ACK) ? PTR_L : WR_DATA;
                        end
                    end
                    WR_DATA: begin
                        if (w_scl_rise) begin
                            r_shift <= w_byte;
                            r_cnt   <= r_cnt + 4'd1;
                            if (r_cnt == 4'd7) begin
                                o_wr_en   <= 1'b1;
                                o_wr_addr <= r_ptr;
                                o_wr_data <= w_byte;
                                r_ptr     <= r_ptr + 16'd1;
                            end
                        end else if (w_scl_fall && r_cnt == 4'd8) begin
                            r_sda_oe <= 1'b1;
                            r_state  <= WR_ACK;
                        end
                    end
                    RD_DATA: begin
                        if (w_scl_rise) begin
                            r_cnt <= r_cnt + 4'd1;
                        end else if (w_scl_fall) begin
                            if (r_cnt == 4'd8) begin
                                r_sda_oe <= 1'b0;
                                r_cnt    <= 4'd0;
                                r_state  <= RD_ACK;
                            end else begin
                                r_shift  <= {r_shift[6:0], 1'b0};
                                r_sda_oe <= ~r_shift[6];
                            end
                        end
                    end
                    RD_ACK: begin
                        if (w_scl_rise) begin
                            r_mack <= ~w_sda;
                        end else if (w_scl_fall) begin
                            if (r_mack) begin
                                r_ptr     <= r_ptr + 16'd1;
                                o_rd_req  <= 1'b1;
                                o_rd_addr <= r_ptr + 16'd1;
                                r_rd_cap  <= 1'b1;
                                r_cnt     <= 4'd0;
                                r_state   <= RD_DATA;
                            end else begin
                                r_state <= WAIT_STOP;
                            end
                        end
                    end
                    WAIT_STOP: begin
                    end
                    default: begin
                        r_state  <= IDLE;
                        r_sda_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave_regif.sv
// Directed bench: a bit-banged I2C master drives the bus, and a scoreboard checks the write and
// read strobes against expected queues.
module tb_i2c_slave_regif;

    localparam time Q = 80ns;

    logic        clk = 1'b0;
    logic        rst;
    logic        scl;
    logic        m_oe;
    wire         sda_bus;
    logic        o_wr_en;
    logic [15:0] o_wr_addr;
    logic [7:0]  o_wr_data;
    logic        o_rd_req;
    logic [15:0] o_rd_addr;
    logic [7:0]  i_rd_data;
    logic        o_busy;
    logic        rd_valid = 1'b0;

    int checks = 0;
    int errors = 0;
    int low_cnt = 0;
    int busy_cnt = 0;
    logic [23:0] exp_wr[$];
    logic [15:0] exp_rd[$];

    always #5ns clk = ~clk;

    pullup (sda_bus);
    assign sda_bus = m_oe ? 1'b0 : 1'bz;

    // Register-file model: data = addr[7:0], valid only in the clk after the request.
    always @(negedge clk) rd_valid <= o_rd_req;
    assign i_rd_data = rd_valid ? o_rd_addr[7:0] : 8'hEE;

    i2c_slave_regif dut (
        .clk       (clk),
        .rst       (rst),
        .i2c_scl   (scl),
        .i2c_sda   (sda_bus),
        .o_wr_en   (o_wr_en),
        .o_wr_addr (o_wr_addr),
        .o_wr_data (o_wr_data),
        .o_rd_req  (o_rd_req),
        .o_rd_addr (o_rd_addr),
        .i_rd_data (i_rd_data),
        .o_busy    (o_busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: pops an expectation whenever the DUT strobes.
    initial begin : monitor
        logic [23:0] ew;
        logic [15:0] er;
        forever begin
            @(negedge clk);
            if (!m_oe && sda_bus === 1'b0) low_cnt++;
            if (o_busy) busy_cnt++;
            if (o_wr_en && o_rd_req) begin
                checks++;
                errors++;
                $display("FAIL strobe_overlap: wr_en=1 rd_req=1 required not both");
            end
            if (o_wr_en) begin
                if (exp_wr.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL wr_unexpected: actual addr=%h data=%h required none", o_wr_addr, o_wr_data);
                end else begin
                    ew = exp_wr.pop_front();
                    check("wr_strobe", 32'({o_wr_addr, o_wr_data}), 32'(ew));
                end
            end
            if (o_rd_req) begin
                if (exp_rd.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rd_unexpected: actual addr=%h required none", o_rd_addr);
                end else begin
                    er = exp_rd.pop_front();
                    check("rd_req", 32'(o_rd_addr), 32'(er));
                end
            end
        end
    end

    task automatic send_bit(input logic b);
        m_oe = ~b;
        #(Q); scl = 1'b1;
        #(2*Q); scl = 1'b0;
        #(Q);
    endtask

    task automatic recv_bit(output logic b);
        m_oe = 1'b0;
        #(Q); scl = 1'b1;
        #(Q); b = sda_bus;
        #(Q); scl = 1'b0;
        #(Q);
    endtask

    task automatic i2c_start();
        m_oe = 1'b0;
        #(Q); scl = 1'b1;
        #(Q); m_oe = 1'b1;
        #(Q); scl = 1'b0;
        #(Q);
    endtask

    task automatic i2c_stop();
        m_oe = 1'b1;
        #(Q); scl = 1'b1;
        #(Q); m_oe = 1'b0;
        #(2*Q);
    endtask

    task automatic wr_byte(input string name, input logic [7:0] d, input logic exp_ack);
        logic a;
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        recv_bit(a);
        check(name, 32'(a), 32'(exp_ack));
    endtask

    task automatic rd_byte(input string name, input logic [7:0] exp_d, input logic ack);
        logic [7:0] d;
        logic b;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(b);
            d[i] = b;
        end
        check(name, 32'(d), 32'(exp_d));
        send_bit(ack);
    endtask

    task automatic check_pending(input string name);
        check(name, 32'(exp_wr.size() + exp_rd.size()), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_sda"},     32'(sda_bus),   32'd1);
        check({tag, "_wr_en"},   32'(o_wr_en),   32'd0);
        check({tag, "_rd_req"},  32'(o_rd_req),  32'd0);
        check({tag, "_wr_addr"}, 32'(o_wr_addr), 32'd0);
        check({tag, "_wr_data"}, 32'(o_wr_data), 32'd0);
        check({tag, "_rd_addr"}, 32'(o_rd_addr), 32'd0);
        check({tag, "_busy"},    32'(o_busy),    32'd0);
    endtask

    initial begin : watchdog
        #3ms;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int l0;
        int b0;
        logic bit7;
        rst  = 1'b1;
        scl  = 1'b1;
        m_oe = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;
        #2;

        // Current-address read right after reset: pointer starts at 0.
        exp_rd.push_back(16'h0000);
        i2c_start();
        wr_byte("t0_dev_ack", 8'hA1, 1'b0);
        rd_byte("t0_rd_byte", 8'h00, 1'b1);
        i2c_stop();
        check_pending("t0_pending");

        // Two-byte write with pointer auto-increment.
        exp_wr.push_back({16'h1234, 8'hAB});
        exp_wr.push_back({16'h1235, 8'hCD});
        i2c_start();
        wr_byte("t1_dev_ack", 8'hA0, 1'b0);
        wr_byte("t1_ptrh_ack", 8'h12, 1'b0);
        wr_byte("t1_ptrl_ack", 8'h34, 1'b0);
        wr_byte("t1_d0_ack", 8'hAB, 1'b0);
        wr_byte("t1_d1_ack", 8'hCD, 1'b0);
        check("t1_busy_mid", 32'(o_busy), 32'd1);
        i2c_stop();
        check("t1_busy_after", 32'(o_busy), 32'd0);
        check_pending("t1_pending");

        // Random read: set pointer, repeated START, read ACK then NACK.
        exp_rd.push_back(16'h0010);
        exp_rd.push_back(16'h0011);
        i2c_start();
        wr_byte("t2_dev_ack", 8'hA0, 1'b0);
        wr_byte("t2_ptrh_ack", 8'h00, 1'b0);
        wr_byte("t2_ptrl_ack", 8'h10, 1'b0);
        i2c_start();
        wr_byte("t2_rdev_ack", 8'hA1, 1'b0);
        rd_byte("t2_rd0", 8'h10, 1'b0);
        rd_byte("t2_rd1", 8'h11, 1'b1);
        i2c_stop();
        check_pending("t2_pending");

        // Address mismatch: bus never pulled low by the DUT, busy never set.
        l0 = low_cnt;
        b0 = busy_cnt;
        i2c_start();
        wr_byte("t3_dev_nack", 8'hA2, 1'b1);
        wr_byte("t3_data_nack", 8'h00, 1'b1);
        i2c_stop();
        check("t3_sda_low_cycles", 32'(low_cnt - l0), 32'd0);
        check("t3_busy_cycles", 32'(busy_cnt - b0), 32'd0);

        // Pointer wrap.
        exp_wr.push_back({16'hFFFF, 8'h55});
        exp_wr.push_back({16'h0000, 8'h66});
        i2c_start();
        wr_byte("t4_dev_ack", 8'hA0, 1'b0);
        wr_byte("t4_ptrh_ack", 8'hFF, 1'b0);
        wr_byte("t4_ptrl_ack", 8'hFF, 1'b0);
        wr_byte("t4_d0_ack", 8'h55, 1'b0);
        wr_byte("t4_d1_ack", 8'h66, 1'b0);
        i2c_stop();
        check_pending("t4_pending");

        // Abort after 4 bits of a data byte; pointer must still be 0x0041.
        exp_wr.push_back({16'h0040, 8'h11});
        i2c_start();
        wr_byte("t5_dev_ack", 8'hA0, 1'b0);
        wr_byte("t5_ptrh_ack", 8'h00, 1'b0);
        wr_byte("t5_ptrl_ack", 8'h40, 1'b0);
        wr_byte("t5_d0_ack", 8'h11, 1'b0);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
        i2c_stop();
        exp_rd.push_back(16'h0041);
        i2c_start();
        wr_byte("t5_rdev_ack", 8'hA1, 1'b0);
        rd_byte("t5_rd", 8'h41, 1'b1);
        i2c_stop();
        check_pending("t5_pending");

        // Reset while the DUT is pulling SDA low for a read bit of 0x20.
        exp_rd.push_back(16'h0020);
        i2c_start();
        wr_byte("t6_dev_ack", 8'hA0, 1'b0);
        wr_byte("t6_ptrh_ack", 8'h00, 1'b0);
        wr_byte("t6_ptrl_ack", 8'h20, 1'b0);
        i2c_start();
        wr_byte("t6_rdev_ack", 8'hA1, 1'b0);
        recv_bit(bit7);
        check("t6_bit7", 32'(bit7), 32'd0);
        check("t6_driving_low", 32'(sda_bus), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outputs("t6_reset");
        @(negedge clk);
        rst = 1'b0;
        #2;
        i2c_stop();
        exp_wr.push_back({16'h0030, 8'h77});
        i2c_start();
        wr_byte("t7_dev_ack", 8'hA0, 1'b0);
        wr_byte("t7_ptrh_ack", 8'h00, 1'b0);
        wr_byte("t7_ptrl_ack", 8'h30, 1'b0);
        wr_byte("t7_d0_ack", 8'h77, 1'b0);
        i2c_stop();
        check("t7_busy_after", 32'(o_busy), 32'd0);
        check_pending("t7_pending");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
